// File: rtl/matrix_pkg.sv
// Shared widths, opcodes and FSM encoding for the 5x5 int8 matrix add sequencer.
package matrix_pkg;

  localparam int unsigned ELEM_W   = 8;
  localparam int unsigned DIM      = 5;
  localparam int unsigned ROW_W    = ELEM_W * DIM;
  localparam int unsigned MAT_W    = ROW_W * DIM;
  localparam int unsigned NUM_ELEM = DIM * DIM;

  localparam logic [2:0] LAST_ROW = 3'(DIM - 1);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD_A = 3'd1;
  localparam logic [2:0] OP_LOAD_B = 3'd2;
  localparam logic [2:0] OP_EXEC   = 3'd3;
  localparam logic [2:0] OP_READ   = 3'd4;
  localparam logic [2:0] OP_CLEAR  = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCapture,
    StStream
  } state_e;

endpackage

// File: rtl/matrix_row_bank.sv
// DIM x ROW_W register bank: single-row write, whole matrix read as one packed bus.
module matrix_row_bank
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [2:0]       waddr_i,
  input  logic [ROW_W-1:0] wdata_i,
  output logic [MAT_W-1:0] mat_o
);

  logic [DIM-1:0][ROW_W-1:0] rows_q, rows_d;

  always_comb begin
    rows_d = rows_q;
    if (clr_i) begin
      rows_d = '0;
    end else begin
      for (int r = 0; r < DIM; r++) begin
        if (we_i && (waddr_i == 3'(r))) rows_d[r] = wdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rows_q <= '0;
    else        rows_q <= rows_d;
  end

  // Row 0 lands in the low bits, so element r*DIM+c sits at [(r*DIM+c)*ELEM_W].
  assign mat_o = rows_q;

endmodule

// File: rtl/matrix_add_sequencer.sv
// Command-driven sequencer for the 5x5 int8 matrix adder: load, settle, capture, stream.
// Optional per-element saturation on capture is enabled by defining MATRIX_SAT_EN.
module matrix_add_sequencer
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_row,
  input  logic [ROW_W-1:0] cmd_data,
  output logic [MAT_W-1:0] add_a,
  output logic [MAT_W-1:0] add_b,
  input  logic [MAT_W-1:0] add_result,
  input  logic             add_overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ROW_W-1:0] res_data,
  output logic [2:0]       res_row,
  output logic             res_last,
  output logic             busy,
  output logic             ovf_sticky,
  output logic             err
);

  state_e           state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [MAT_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             cmd_fire, row_ok;
  logic             a_we, b_we, bank_clr;
  logic [MAT_W-1:0] cap_result;
  logic             cap_ovf;

  assign cmd_ready = (state_q == StIdle) && rst_n;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign row_ok    = (cmd_row <= LAST_ROW);

  matrix_row_bank u_bank_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (bank_clr),
    .we_i    (a_we),
    .waddr_i (cmd_row),
    .wdata_i (cmd_data),
    .mat_o   (add_a)
  );

  matrix_row_bank u_bank_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (bank_clr),
    .we_i    (b_we),
    .waddr_i (cmd_row),
    .wdata_i (cmd_data),
    .mat_o   (add_b)
  );

`ifdef MATRIX_SAT_EN
  logic unused_add_overflow;
  assign unused_add_overflow = add_overflow;

  // Signed overflow only when operands agree in sign and the sum does not.
  always_comb begin
    cap_result = add_result;
    cap_ovf    = 1'b0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      logic [ELEM_W-1:0] ea, eb, es;
      ea = add_a[i*ELEM_W +: ELEM_W];
      eb = add_b[i*ELEM_W +: ELEM_W];
      es = add_result[i*ELEM_W +: ELEM_W];
      if ((ea[ELEM_W-1] == eb[ELEM_W-1]) && (es[ELEM_W-1] != ea[ELEM_W-1])) begin
        cap_ovf = 1'b1;
        cap_result[i*ELEM_W +: ELEM_W] = ea[ELEM_W-1] ? 8'h80 : 8'h7F;
      end
    end
  end
`else
  assign cap_result = add_result;
  assign cap_ovf    = add_overflow;
`endif

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = 1'b0;
    a_we     = 1'b0;
    b_we     = 1'b0;
    bank_clr = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_NOP: ;
            OP_LOAD_A: begin
              if (row_ok) a_we  = 1'b1;
              else        err_d = 1'b1;
            end
            OP_LOAD_B: begin
              if (row_ok) b_we  = 1'b1;
              else        err_d = 1'b1;
            end
            OP_EXEC: begin
              ovf_d   = 1'b0;
              state_d = StSettle;
            end
            OP_READ: begin
              row_d   = '0;
              state_d = StStream;
            end
            OP_CLEAR: begin
              bank_clr = 1'b1;
              result_d = '0;
              ovf_d    = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StSettle: state_d = StCapture;
      StCapture: begin
        result_d = cap_result;
        ovf_d    = cap_ovf;
        state_d  = StIdle;
      end
      StStream: begin
        if (res_ready) begin
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = StIdle;
          end else begin
            row_d = row_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      row_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign res_valid  = (state_q == StStream);
  assign res_data   = result_q[int'(row_q)*ROW_W +: ROW_W];
  assign res_row    = row_q;
  assign res_last   = res_valid && (row_q == LAST_ROW);
  assign busy       = (state_q != StIdle);
  assign ovf_sticky = ovf_q;
  assign err        = err_q;

endmodule

// File: doc/matrix_add_sequencer.md
Name: matrix_add_sequencer

Overview:
Command-driven controller that sequences the 5x5 int8 matrix adder datapath in the coprocessor.
- Loads operand matrices A and B row by row from a command port.
- Drives the combinational adder, waits one settle cycle, then captures the 200-bit result and overflow flag.
- Streams the result back row by row over a valid/ready port.
- Sits between the host command decoder and the adder instance.

Parameters:
ELEM_W, 8, element width in bits (signed two's complement)
DIM, 5, matrix dimension; rows = columns = DIM
ROW_W, ELEM_W*DIM = 40, width of one row bus
MAT_W, ELEM_W*DIM*DIM = 200, width of packed matrix

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  3  0=NOP 1=LOAD_A 2=LOAD_B 3=EXEC 4=READ 5=CLEAR; 6,7 reserved
cmd_row  in  3  row index for LOAD_A/LOAD_B
cmd_data  in  ROW_W  row payload; element c at bits [c*8 +: 8]
add_a  out  MAT_W  operand A to adder; element i=r*5+c at [i*8 +: 8]
add_b  out  MAT_W  operand B to adder, same packing
add_result  in  MAT_W  adder sum
add_overflow  in  1  adder overflow flag
res_valid  out  1  result row valid
res_ready  in  1  consumer accepts row
res_data  out  ROW_W  result row
res_row  out  3  index of row on res_data
res_last  out  1  high with row 4
busy  out  1  high in any state other than IDLE
ovf_sticky  out  1  overflow of last EXEC; cleared by CLEAR or next EXEC
err  out  1  one-cycle pulse on bad row index or reserved opcode

Behaviour:
Reset (rst_n low at a clock edge):
- State to IDLE.
- A, B and result registers all zero.
- Outputs cmd_ready=0 during reset; res_valid=0, res_row=0, res_last=0, busy=0, ovf_sticky=0, err=0.
- A reset mid-EXEC or mid-STREAM aborts the operation immediately. No partial state survives.

States: IDLE, SETTLE, CAPTURE, STREAM. cmd_ready = (state==IDLE) && rst_n.

IDLE:
- LOAD_A/LOAD_B with cmd_row<=4: row written into the A/B register next cycle; stay in IDLE.
- LOAD_A/LOAD_B with cmd_row>=5: command accepted, no write, err=1 for 1 cycle.
- EXEC: go to SETTLE.
- READ: go to STREAM with row counter at 0.
- CLEAR: zero A, B, result and ovf_sticky.
- NOP: no effect.
- Reserved opcode: accepted, err pulse, no other effect.

SETTLE:
- One cycle; add_a/add_b are stable register outputs. Go to CAPTURE.

CAPTURE:
- Result register <= add_result (or the saturated value, see Optional Feature).
- ovf_sticky <= add_overflow.
- Return to IDLE.
- EXEC command-to-IDLE latency is 2 cycles after acceptance.

STREAM:
- res_valid=1; res_data = result row[counter]; res_row = counter; res_last = (counter==4).
- On res_valid && res_ready: increment counter. After row 4 is accepted, return to IDLE.
- Row is held stable while res_ready=0; no timeout.

Other rules:
- Arithmetic is modulo 2^8 per element; the sequencer does no arithmetic except in the optional feature.
- add_a/add_b are driven directly from the A/B registers in every state.
- A LOAD accepted in the cycle before EXEC is visible to that EXEC, because EXEC cannot be accepted until the following cycle.
- READ before any EXEC streams zeros.

Optional Feature:
Macro MATRIX_SAT_EN.
- Defined: in CAPTURE, each element is saturated independently. Overflow condition: sign(A_i)==sign(B_i) and sign(add_result_i)!=sign(A_i). Overflowed elements are stored as 8'h7F if A_i is positive, 8'h80 if A_i is negative. ovf_sticky is the OR of the per-element conditions; add_overflow is ignored.
- Undefined: the wrapped add_result is stored unchanged and ovf_sticky = add_overflow.

Decomposition:
- Shared package matrix_pkg: ELEM_W, DIM, ROW_W, MAT_W; opcode constants OP_NOP, OP_LOAD_A, OP_LOAD_B, OP_EXEC, OP_READ, OP_CLEAR; state encoding.
- One natural sub-module: matrix_row_bank (5x40-bit register bank with row write and packed 200-bit read), instantiated twice for A and B.
- Saturation logic stays inline, under the macro.

Test Plan:
- Load A with all rows 0x01 per element and B with all rows 0x02; EXEC; READ -> 5 rows of 40'h0303030303, res_last on row 4, ovf_sticky=0.
- A element 0 = 0x7F, B element 0 = 0x01; EXEC:
  - without MATRIX_SAT_EN -> row 0 byte 0 = 0x80, ovf_sticky=1;
  - with MATRIX_SAT_EN -> 0x7F, ovf_sticky=1.
- A element 24 = 0x80, B element 24 = 0xFF; with MATRIX_SAT_EN -> row 4 byte 4 = 0x80, ovf_sticky=1.
- LOAD_A with cmd_row=6, then op=7 -> two err pulses; A register unchanged; cmd_ready stays 1.
- During READ, hold res_ready=0 for 4 cycles on row 2 -> res_data/res_row stable; cmd_ready=0 and busy=1 throughout.
- Assert rst_n=0 for one cycle while in SETTLE -> next cycle IDLE with busy=0 and all registers zero; a subsequent READ streams zeros.
